// File: rtl/nn_decision_filter.sv
// nn_decision_filter
//   Debounces the per-segment classifications coming out of the neural-net
//   word detector. It keeps a sliding window of the last WIN classes, counts
//   votes per class and fires one detect pulse when a non-silence class
//   collects THRESH votes. After a detection it ignores HOLDOFF frames. If
//   the detector goes quiet for TIMEOUT cycles, the history is flushed.
//
// Ports
//   clk           in   global clock
//   reset         in   asynchronous reset, active-high
//   result_dv     in   one-cycle strobe, new classification available
//   result[1:0]   in   class, 0 = silence, 1..3 = word classes
//   detect        out  one-cycle pulse, word detected
//   detect_class  out  class of the last detection, held until the next one
//   holdoff       out  high while post-detection frames are being discarded
//   fill_level    out  number of valid frames in the window (0..WIN)
module nn_decision_filter #(
  parameter int WIN     = 8,
  parameter int THRESH  = 6,
  parameter int HOLDOFF = 4,
  parameter int TIMEOUT = 2000000,
  parameter int CW      = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          result_dv,
  input  logic [1:0]    result,
  output logic          detect,
  output logic [1:0]    detect_class,
  output logic          holdoff,
  output logic [CW-1:0] fill_level
);

  localparam int PW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [CW-1:0] WIN_C    = CW'(WIN);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
  localparam logic [PW-1:0] PTR_LAST = PW'(WIN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_C   = HW'(HOLDOFF);

  // A strict majority threshold guarantees at most one class can qualify.
  if (!((THRESH > WIN / 2) && (THRESH <= WIN))) begin : g_bad_thresh
    $error("nn_decision_filter: THRESH must satisfy WIN/2 < THRESH <= WIN");
  end
  if (WIN >= (1 << CW)) begin : g_bad_cw
    $error("nn_decision_filter: CW too narrow to hold WIN");
  end

  typedef enum logic [1:0] {S_FILL, S_RUN, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [1:0]    win_q [WIN];
  logic [1:0]    win_d [WIN];
  logic [PW-1:0] wp_q, wp_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [CW-1:0] fill_q, fill_d;
  logic [TW-1:0] to_q, to_d;
  logic [HW-1:0] hc_q, hc_d;
  logic          detect_q, detect_d;
  logic [1:0]    cls_q, cls_d;
  logic          holdoff_q, holdoff_d;

  logic          flush;
  logic          hit;
  logic [1:0]    hit_cls;
  logic [1:0]    evicted;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    wp_d     = wp_q;
    cnt_d    = cnt_q;
    fill_d   = fill_q;
    to_d     = to_q;
    hc_d     = hc_q;
    detect_d = 1'b0;
    cls_d    = cls_q;
    flush    = 1'b0;
    hit      = 1'b0;
    hit_cls  = 2'd0;
    evicted  = win_q[wp_q];

    if (state_q == S_HOLD) begin
      // Frames are discarded here and the inactivity timer is parked.
      to_d = '0;
      if (result_dv) begin
        if (hc_q <= HW'(1)) begin
          state_d = S_FILL;
          hc_d    = '0;
        end else begin
          hc_d = hc_q - HW'(1);
        end
      end
    end else if (result_dv) begin
      // A frame on the expiry cycle takes priority over the flush.
      to_d        = '0;
      win_d[wp_q] = result;
      wp_d        = (wp_q == PTR_LAST) ? '0 : wp_q + PW'(1);
      if (fill_q == WIN_C) begin
        // Full window: oldest entry leaves as the new one arrives.
        if (evicted != result) begin
          cnt_d[evicted] = cnt_q[evicted] - CW'(1);
          cnt_d[result]  = cnt_q[result] + CW'(1);
        end
      end else begin
        cnt_d[result] = cnt_q[result] + CW'(1);
        fill_d        = fill_q + CW'(1);
      end

      if (state_q == S_FILL) begin
        if (fill_d == WIN_C) state_d = S_RUN;
      end else begin
        for (int k = 1; k < 4; k++) begin
          if (cnt_d[k] >= THRESH_C) begin
            hit     = 1'b1;
            hit_cls = 2'(k);
          end
        end
      end

      if (hit) begin
        detect_d = 1'b1;
        cls_d    = hit_cls;
        flush    = 1'b1;
        if (HOLDOFF > 0) begin
          state_d = S_HOLD;
          hc_d    = HOLD_C;
        end else begin
          state_d = S_FILL;
        end
      end
    end else if (to_q == TO_LAST) begin
      flush   = 1'b1;
      state_d = S_FILL;
      to_d    = '0;
    end else begin
      to_d = to_q + TW'(1);
    end

    if (flush) begin
      for (int i = 0; i < WIN; i++) win_d[i] = 2'd0;
      for (int c = 0; c < 4; c++) cnt_d[c] = '0;
      wp_d   = '0;
      fill_d = '0;
    end

    holdoff_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FILL;
      for (int i = 0; i < WIN; i++) win_q[i] <= 2'd0;
      for (int c = 0; c < 4; c++) cnt_q[c] <= '0;
      wp_q      <= '0;
      fill_q    <= '0;
      to_q      <= '0;
      hc_q      <= '0;
      detect_q  <= 1'b0;
      cls_q     <= 2'd0;
      holdoff_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      wp_q      <= wp_d;
      fill_q    <= fill_d;
      to_q      <= to_d;
      hc_q      <= hc_d;
      detect_q  <= detect_d;
      cls_q     <= cls_d;
      holdoff_q <= holdoff_d;
    end
  end

  assign detect       = detect_q;
  assign detect_class = cls_q;
  assign holdoff      = holdoff_q;
  assign fill_level   = fill_q;

endmodule

// File: tb/tb_nn_decision_filter.sv
// Testbench for nn_decision_filter (WIN=8, THRESH=6, HOLDOFF=4, TIMEOUT=100).
// A behavioural model built on a frame history queue predicts every cycle;
// predicted detections go into a scoreboard queue that a negedge monitor
// drains whenever the DUT pulses detect.
module tb_nn_decision_filter;

  localparam int WIN     = 8;
  localparam int THRESH  = 6;
  localparam int HOLDOFF = 4;
  localparam int TIMEOUT = 100;
  localparam int CW      = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          result_dv;
  logic [1:0]    result;
  logic          detect;
  logic [1:0]    detect_class;
  logic          holdoff;
  logic [CW-1:0] fill_level;

  int n_tests = 0;
  int n_fail  = 0;

  nn_decision_filter #(
    .WIN(WIN), .THRESH(THRESH), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .result_dv(result_dv), .result(result),
    .detect(detect), .detect_class(detect_class), .holdoff(holdoff),
    .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit [1:0] hist[$];
  bit [1:0] sb_q[$];
  int       m_st;      // 0 fill, 1 run, 2 holdoff
  int       m_to;
  int       m_hc;
  bit       m_det;
  bit [1:0] m_cls;
  bit       m_hold;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    sb_q.delete();
    m_st = 0; m_to = 0; m_hc = 0;
    m_det = 1'b0; m_cls = 2'd0; m_hold = 1'b0;
  endtask

  task automatic model_step(input bit dv, input bit [1:0] r);
    int c[4];
    m_det = 1'b0;
    if (m_st == 2) begin
      if (dv) begin
        m_hc--;
        if (m_hc == 0) m_st = 0;
      end
    end else if (dv) begin
      m_to = 0;
      hist.push_back(r);
      if (hist.size() > WIN) void'(hist.pop_front());
      if (m_st == 0) begin
        if (hist.size() == WIN) m_st = 1;
      end else begin
        c = '{default: 0};
        foreach (hist[i]) c[hist[i]]++;
        for (int k = 1; k < 4; k++)
          if (c[k] >= THRESH) begin
            m_det = 1'b1;
            m_cls = 2'(k);
          end
        if (m_det) begin
          hist.delete();
          m_hc = HOLDOFF;
          m_st = (HOLDOFF > 0) ? 2 : 0;
          sb_q.push_back(m_cls);
        end
      end
    end else if (m_to == TIMEOUT - 1) begin
      hist.delete();
      m_st = 0;
      m_to = 0;
    end else begin
      m_to++;
    end
    m_hold = (m_st == 2);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model with it.
  task automatic cycle(input bit dv, input bit [1:0] r);
    result_dv = dv;
    result    = r;
    @(posedge clk);
    model_step(dv, r);
    #1;
    result_dv = 1'b0;
    result    = 2'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 2'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    #1;
    check("rst_detect", detect, 0);
    check("rst_class", detect_class, 0);
    check("rst_holdoff", holdoff, 0);
    check("rst_fill", fill_level, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: per-cycle comparison against the model plus scoreboard drain.
  always @(negedge clk) begin
    int sum;
    bit [1:0] exp_cls;
    check("mon_detect", detect, m_det);
    check("mon_fill", fill_level, hist.size());
    check("mon_holdoff", holdoff, m_hold);
    check("mon_class", detect_class, m_cls);
    if (detect) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_detect", 1, 0);
      end else begin
        exp_cls = sb_q.pop_front();
        check("sb_class", detect_class, exp_cls);
      end
    end
    sum = 0;
    for (int c = 0; c < 4; c++) begin
      sum += int'(dut.cnt_q[c]);
      if (int'(dut.cnt_q[c]) > WIN) check("cnt_overflow", int'(dut.cnt_q[c]), WIN);
    end
    check("cnt_sum", sum, fill_level);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    result_dv = 1'b0;
    result    = 2'd0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("init_detect", detect, 0);
    check("init_fill", fill_level, 0);
    check("init_holdoff", holdoff, 0);
    reset = 1'b0;

    // Class 2 every 5 clk: fills without detecting, 9th frame fires.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 2'd2);
      check("fill_step", fill_level, i);
      check("fill_nodet", detect, 0);
      idle(4);
    end
    cycle(1'b1, 2'd2);
    check("f9_detect", detect, 1);
    check("f9_class", detect_class, 2);
    check("f9_holdoff", holdoff, 1);
    check("f9_fill", fill_level, 0);
    cycle(1'b0, 2'd0);
    check("f9_pulse_once", detect, 0);

    // Hold-off: four class-3 frames discarded, holdoff drops after the 4th.
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 2'd3);
      check("ho_nodet", detect, 0);
      check("ho_fill", fill_level, 0);
      check("ho_flag", holdoff, (i < 4) ? 1 : 0);
      idle(1);
    end
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 2'd3);
      check("c3_nodet", detect, 0);
    end
    cycle(1'b1, 2'd3);
    check("c3_detect", detect, 1);
    check("c3_class", detect_class, 3);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 2'd0);
      idle(1);
    end
    check("c3_ho_done", holdoff, 0);

    // Mixed window: 1s reach six only after the leading 1s and a 0 are evicted.
    begin
      bit [1:0] pat [8] = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd3};
      for (int i = 0; i < 8; i++) cycle(1'b1, pat[i]);
    end
    check("pat_fill", fill_level, 8);
    cycle(1'b1, 2'd1);
    check("pat_nodet1", detect, 0);
    cycle(1'b1, 2'd1);
    check("pat_nodet2", detect, 0);
    cycle(1'b1, 2'd1);
    check("pat_detect", detect, 1);
    check("pat_class", detect_class, 1);
    cycle(1'b0, 2'd0);
    check("pat_once", detect, 0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'd2);
    check("pat_ho_done", holdoff, 0);

    // Inactivity timeout flushes the window; a frame on expiry wins.
    for (int i = 0; i < 5; i++) cycle(1'b1, 2'd1);
    check("to_fill5", fill_level, 5);
    idle(99);
    check("to_before", fill_level, 5);
    idle(1);
    check("to_flushed", fill_level, 0);
    idle(99);
    cycle(1'b1, 2'd1);
    check("to_frame_wins", fill_level, 1);
    idle(2);
    check("to_no_flush", fill_level, 1);

    // Reset mid-RUN after 10 frames.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, (i % 2) ? 2'd2 : 2'd1);
    check("mr_fill", fill_level, 8);
    do_reset();
    cycle(1'b1, 2'd3);
    check("mr_restart", fill_level, 1);

    // Random traffic against the model, including back-to-back strobes.
    for (int i = 0; i < 2000; i++) begin
      cycle(1'b1, 2'($urandom_range(0, 3)));
      idle($urandom_range(0, 3));
    end
    idle(3);
    check("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_decision_filter.md
Name: nn_decision_filter

Overview:
- Post-processing stage directly downstream of the neural-net word detector.
- Consumes the per-segment classification strobe (result_dv, 2-bit result) and applies a sliding-window majority vote, a post-detection hold-off and an inter-frame timeout.
- Emits one clean, debounced word-detection event per spoken word, so the rest of the system never sees flickering per-segment decisions.

Parameters:
- WIN, 8, sliding-window length in classification frames (2..32).
- THRESH, 6, minimum votes for one non-zero class within the window to fire; must satisfy WIN/2 < THRESH <= WIN (checked at elaboration, $error otherwise).
- HOLDOFF, 4, classification frames discarded after a detection.
- TIMEOUT, 2000000, clk cycles with no result_dv before history is flushed.
- CW, 6, width of the per-class vote counters; must hold WIN.

Ports:
- clk  in  1  global clock.
- reset  in  1  asynchronous reset, active-high.
- result_dv  in  1  one-cycle strobe: new classification available.
- result  in  2  class of the classification; 0 = no word / silence, 1..3 = word classes.
- detect  out  1  one-cycle pulse: word detected.
- detect_class  out  2  class of the last detection; held until the next detect.
- holdoff  out  1  high while in HOLDOFF state.
- fill_level  out  CW  number of valid frames in the window (0..WIN).

Behaviour:
- Reset (asynchronous, reset=1), effective immediately and mid-operation, from any state:
  - state=FILL, window cleared, all four vote counters=0, fill_level=0.
  - holdoff=0, detect=0, detect_class=0, timeout counter=0, hold-off counter=0.
- Window storage: circular buffer of WIN 2-bit entries with a write pointer; pointer wraps from WIN-1 to 0.
- Vote counters cnt[0..3]: updated incrementally on each accepted frame.
  - cnt[result]+1.
  - When fill_level==WIN, also cnt[evicted entry]-1 in the same cycle. If evicted==result, the counter is unchanged.
  - Counters never exceed WIN and never underflow; the bench asserts both.
- fill_level increments per accepted frame and saturates at WIN.
- States:
  - FILL: accept frames. When fill_level reaches WIN (on that frame's update), go to RUN. No detection is possible while in FILL.
  - RUN: accept frames. After each update, if the post-update cnt[k] >= THRESH for some k in 1..3, detection fires:
    - detect=1 on the cycle after the triggering result_dv (latency 1 clk).
    - detect_class=k on that same cycle.
    - Window, counters and fill_level cleared; hold-off counter loaded with HOLDOFF; go to HOLDOFF.
    - THRESH > WIN/2 guarantees at most one k qualifies. Class 0 never fires.
  - HOLDOFF: holdoff=1. Each result_dv decrements the counter; frames are not stored. On the strobe that brings the counter to 0, go to FILL and deassert holdoff on the next cycle. If HOLDOFF=0, go straight from detection to FILL.
- Timeout:
  - The counter increments every cycle in FILL/RUN and clears on result_dv.
  - On reaching TIMEOUT-1 without a strobe: clear window, counters and fill_level, and go to FILL.
  - The counter is inactive in HOLDOFF.
  - If result_dv coincides with the expiry cycle, the frame wins: it is accepted and the counter resets.
- detect is registered and high for exactly one cycle. Back-to-back result_dv on consecutive cycles must be accepted without loss.
- Implementation is fully synchronous apart from the asynchronous reset, with no combinational path from inputs to outputs.

Test Plan (WIN=8, THRESH=6, HOLDOFF=4, TIMEOUT=100):
- Reset mid-RUN after 10 frames -> all outputs 0 immediately (same cycle as reset), fill_level=0; next frames restart FILL.
- 8 frames of class 2 spaced 5 clk -> fill_level 1..8; the 8th frame completes the fill, so there is no detect through frame 8. Frame 9 (class 2) -> detect=1 one clk after its strobe, detect_class=2, holdoff=1.
- Window pattern 1,1,0,1,1,1,0,3 in RUN, then feed 1 -> 1s only reach 6 at that point (earlier evictions keep cnt[1]<6) -> detect only when cnt[1]==6; fires exactly once, detect_class=1.
- After a detect, feed 4 frames of class 3 -> no detect, holdoff falls after the 4th strobe. Then 8 frames of class 3 fill the window; the 9th frame triggers detect with class 3.
- 5 frames of class 1, then 100 idle clk -> fill_level returns to 0. Repeat with a result_dv landing on the expiry cycle -> fill_level=1, no flush.
- 2000 random result values with random spacing (including consecutive-cycle strobes) vs. a reference model -> identical detect timing and class; counter sum always equals fill_level.
